// File: rtl/lenet_fixed_pkg.sv
// Shared fixed-point definitions for the LeNet-5 datapath.
// Values are sign-magnitude Q7.10: bit 17 is the sign, 16:10 the integer part, 9:0 the fraction.
package lenet_fixed_pkg;

  localparam int DW     = 18;
  localparam int FRAC_W = 10;
  localparam int MAG_W  = DW - 1;

  localparam logic [DW-1:0]    ONE     = 18'h00400;
  localparam logic [MAG_W-1:0] MAG_MAX = 17'h1FFFF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_t;

  // A value with zero magnitude is always carried as +0.
  function automatic sm_t sm_norm(input sm_t v);
    sm_t r;
    r = v;
    if (v.mag == '0) r.sign = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fixed_productor.sv
// Combinational sign-magnitude Q7.10 multiplier.
// The fraction is truncated and magnitude overflow wraps mod 2^17.
module fixed_productor
  import lenet_fixed_pkg::*;
(
  input  sm_t a_i,
  input  sm_t b_i,
  output sm_t p_o
);

  logic [2*MAG_W-1:0] full_mag;
  logic [MAG_W-1:0]   mag;

  assign full_mag = {{MAG_W{1'b0}}, a_i.mag} * {{MAG_W{1'b0}}, b_i.mag};
  assign mag      = MAG_W'(full_mag >> FRAC_W);

  assign p_o.mag  = mag;
  assign p_o.sign = (a_i.sign ^ b_i.sign) & (|mag);

endmodule

// File: rtl/sm_sat_adder.sv
// Combinational sign-magnitude adder that clamps the magnitude at MAG_MAX
// and flags the clamp on sat_o.
module sm_sat_adder
  import lenet_fixed_pkg::*;
(
  input  sm_t  a_i,
  input  sm_t  b_i,
  output sm_t  y_o,
  output logic sat_o
);

  logic [MAG_W:0] mag_sum;

  assign mag_sum = {1'b0, a_i.mag} + {1'b0, b_i.mag};

  // NOTE: every output gets a default first so no path through the branches infers a latch.
  always_comb begin
    y_o   = '0;
    sat_o = 1'b0;
    if (a_i.sign == b_i.sign) begin
      y_o.sign = a_i.sign;
      if (mag_sum[MAG_W]) begin
        y_o.mag = MAG_MAX;
        sat_o   = 1'b1;
      end else begin
        y_o.mag = mag_sum[MAG_W-1:0];
      end
    end else if (a_i.mag >= b_i.mag) begin
      y_o.sign = a_i.sign;
      y_o.mag  = a_i.mag - b_i.mag;
    end else begin
      y_o.sign = b_i.sign;
      y_o.mag  = b_i.mag - a_i.mag;
    end
    if (y_o.mag == '0) y_o.sign = 1'b0;
  end

endmodule

// File: rtl/conv_mac_scheduler.sv
// Streams TAPS weight/pixel pairs through one shared multiplier, accumulates
// onto the bias and hands back one saturated result per job over valid/ready.
module conv_mac_scheduler
  import lenet_fixed_pkg::*;
#(
  parameter int TAPS   = 25,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DW-1:0]     bias,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DW-1:0]     w_data,
  input  logic [DW-1:0]     x_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              sat
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_v_q;
  logic              prod_v_q;
  sm_t               prod_q;
  sm_t               acc_q, acc_d;
  logic              sat_q, sat_d;
  sm_t               out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  sm_t  prod_c;
  sm_t  sum_c;
  logic sum_sat_c;

  fixed_productor u_mul (
    .a_i (w_data),
    .b_i (x_data),
    .p_o (prod_c)
  );

  sm_sat_adder u_add (
    .a_i   (acc_q),
    .b_i   (prod_q),
    .y_o   (sum_c),
    .sat_o (sum_sat_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (prod_v_q) begin
      acc_d = sum_c;
      sat_d = sat_q | sum_sat_c;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = sm_norm(bias);
          sat_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == ADDR_W'(TAPS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // The last product is being folded in when nothing is left in the read pipe.
        if (prod_v_q && !rd_v_q) begin
          out_data_d  = sum_c;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_v_q      <= 1'b0;
      prod_v_q    <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_v_q      <= rd_en;
      prod_v_q    <= rd_v_q;
      prod_q      <= prod_c;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign rd_en     = (state_q == ST_RUN);
  assign w_addr    = cnt_q;
  assign x_addr    = cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;

endmodule

// File: doc/conv_mac_scheduler.md
# conv_mac_scheduler

Sequences one convolution window through a single shared 18-bit sign-magnitude fixed-point multiplier (`fixed_productor`: bit 17 sign, 16:10 integer, 9:0 fraction) and accumulates the products onto a bias. It fetches TAPS weight/pixel pairs from synchronous-read memories and returns one saturated sign-magnitude result per job over a valid/ready handshake. It sits between the LeNet-5 layer sequencer, which issues `start`, and the pooling/activation stage, which consumes `out_data`.

## Interface
- TAPS, 25, weight/pixel pairs per job (≥2)
- ADDR_W, 5, address width; 2^ADDR_W ≥ TAPS
- DW, 18, data width; fixed, sign-magnitude Q7.10
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; honoured only in IDLE
- bias  in  DW  sampled on the accepted `start`
- busy  out  1  high in RUN, DRAIN, DONE
- rd_en  out  1  memory read strobe
- w_addr, x_addr  out  ADDR_W  weight/pixel read address (equal values)
- w_data, x_data  in  DW  read data, valid exactly 1 cycle after `rd_en`
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  DW  accumulated result
- sat  out  1  result saturated during this job; valid with `out_valid`

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start`, set acc = bias (−0 normalised to +0), clear sat, clear tap counter, go to RUN.
- RUN: assert `rd_en`, address = counter, increment by 1 each cycle. After address TAPS−1 is issued, go to DRAIN.
- Datapath: returned `w_data`/`x_data` feed the multiplier combinationally. The product is registered in prod_q with prod_v. When prod_v is set, acc ← sm_add(acc, prod_q).
- DRAIN: waits until the last product has been accumulated, then loads `out_data` = acc, sets `out_valid`, and goes to DONE.
- DONE: hold `out_data` and `sat` stable while `out_ready` = 0. On `out_ready` = 1, clear `out_valid` and go to IDLE.
- `start` outside IDLE is ignored; no queuing.
- Multiplier magnitude overflow wraps mod 2^17 inside the multiplier. The controller does not detect it.
- sm_add rules:
  - Equal signs: add magnitudes.
  - Different signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
  - Magnitude > 0x1FFFF: clamp to 0x1FFFF, keep the sign, set sat (sticky for the job).
  - A zero magnitude always gives sign 0.
- Reset: all state cleared, any job in flight is discarded, state goes to IDLE.

## Timing
- Cycle 0: `start` is high in IDLE.
- Cycles 1..TAPS: `rd_en` = 1, addresses 0..TAPS−1.
- Cycles 2..TAPS+1: data returns; prod_q is registered at the end of each of these cycles.
- Cycles 3..TAPS+2: acc updates.
- Cycle TAPS+3: `out_valid` rises (28 for TAPS = 25).
- If `out_ready` is already high, the transfer happens in cycle TAPS+3. IDLE is reached in cycle TAPS+4, and a new `start` can be accepted there. Throughput is one job per TAPS+4 cycles.
- Reset values: busy 0, rd_en 0, w_addr 0, x_addr 0, out_valid 0, out_data 0, sat 0.
- `rst` has priority over every other input in the same cycle, including `start` and `out_ready`.

## Structure
- Package `lenet_fixed_pkg`:
  - DW, FRAC_W = 10
  - ONE = 18'h00400, MAG_MAX = 17'h1FFFF
  - state enum
  - sign-magnitude typedef
- Sub-module `sm_sat_adder`: combinational sign-magnitude add with saturation and sat output.
- One `fixed_productor` instance.
- All other logic (FSM, counter, prod_q, acc) lives in the top module.

## Test plan
- All weights = 0x00400, all pixels = 0x00400, bias 0, `out_ready` = 1 → `out_data` = 0x06400, sat 0, `out_valid` exactly at cycle 28, 25 `rd_en` pulses.
- Weights alternate +1.0/−1.0 (even/odd tap), pixels 0x00800, bias 0 → `out_data` = 0x00800.
- Weights 0x1FC00 (127.0), pixels 0x00400 → `out_data` = 0x1FFFF, sat 1. Then all-zero memories with bias 0x20200 → `out_data` = 0x20200, sat 0.
- Signed cancellation to zero: bias 0x20400 (−1.0) with tap 0 products giving +1.0 and all others 0 → `out_data` = 0x00000; sign bit is never 1 at zero.
- `out_ready` held low 10 cycles after `out_valid`, with `start` pulsed meanwhile → `out_data`/`sat` stable, `start` ignored. After `out_ready` is raised, IDLE is reached the next cycle.
- `rst` asserted at cycle 10 of a job → next cycle all outputs at reset values. A new `start` after reset gives the correct result (0x06400) with 28-cycle latency.
